// File: rtl/gonso_wb_arbiter_if.sv
// Wishbone point-to-point bundle shared by masters and the gonso slave port.
// The master modport drives the request side; the slave modport returns ack and read data.
`timescale 1ns/1ps
interface gonso_wb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/gonso_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the gonso slave; grant held for the whole cyc.
// Latency: request to grant 1 cycle, one IDLE cycle between grants; ack/data forwarded combinationally.
// Backpressure: non-owner sees no ack and must hold; GONSO_WB_ARB_TIMEOUT_EN adds stall-timeout termination.
`timescale 1ns/1ps
module gonso_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gonso_wb_arbiter_if.slave     m0,
  gonso_wb_arbiter_if.slave     m1,
  gonso_wb_arbiter_if.master    s,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("gonso_wb_arbiter: TIMEOUT must be within 1..65535");
  end

  // One-hot encoding lets grant_o be the state register itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_owner_q, last_owner_d;

  logic            req0, req1;
  logic            o_cyc, o_stb, o_we;
  logic [DW/8-1:0] o_sel;
  logic [AW-1:0]   o_adr;
  logic [DW-1:0]   o_dat;
  logic            fwd_ack;
  logic [DW-1:0]   fwd_dat;

`ifdef GONSO_WB_ARB_TIMEOUT_EN
  localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [DW-1:0] BEEF    = DW'(32'hDEAD_BEEF);
  logic [15:0] stall_q, stall_d;
  logic        to_hit;
`endif

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  always_comb begin
    o_cyc = m0.cyc;
    o_stb = m0.stb;
    o_we  = m0.we;
    o_sel = m0.sel;
    o_adr = m0.adr;
    o_dat = m0.dat_w;
    if (state_q == GNT1) begin
      o_cyc = m1.cyc;
      o_stb = m1.stb;
      o_we  = m1.we;
      o_sel = m1.sel;
      o_adr = m1.adr;
      o_dat = m1.dat_w;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    s.cyc        = 1'b0;
    s.stb        = 1'b0;
    s.we         = 1'b0;
    s.sel        = '0;
    s.adr        = '0;
    s.dat_w      = '0;
    fwd_ack      = 1'b0;
    fwd_dat      = '0;
`ifdef GONSO_WB_ARB_TIMEOUT_EN
    stall_d      = stall_q;
    to_hit       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef GONSO_WB_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
        // On a tie, the master that did not own the bus last time wins.
        if (req0 && (!req1 || last_owner_q)) begin
          state_d      = GNT0;
          last_owner_d = 1'b0;
        end else if (req1) begin
          state_d      = GNT1;
          last_owner_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        s.cyc   = o_cyc;
        s.stb   = o_stb;
        s.we    = o_we;
        s.sel   = o_sel;
        s.adr   = o_adr;
        s.dat_w = o_dat;
        fwd_ack = s.ack;
        fwd_dat = s.dat_r;
        if (!o_cyc) state_d = IDLE;
`ifdef GONSO_WB_ARB_TIMEOUT_EN
        if (s.ack) begin
          stall_d = '0;
        end else if (o_stb) begin
          if (stall_q == TO_LAST) begin
            to_hit  = 1'b1;
            s.cyc   = 1'b0;
            s.stb   = 1'b0;
            fwd_ack = 1'b1;
            fwd_dat = BEEF;
            state_d = IDLE;
            stall_d = '0;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the owner ever sees the slave's ack and data.
  always_comb begin
    m0.ack   = 1'b0;
    m0.dat_r = '0;
    m1.ack   = 1'b0;
    m1.dat_r = '0;
    if (state_q == GNT0) begin
      m0.ack   = fwd_ack;
      m0.dat_r = fwd_dat;
    end
    if (state_q == GNT1) begin
      m1.ack   = fwd_ack;
      m1.dat_r = fwd_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef GONSO_WB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
  assign timeout_o = to_hit;
`else
  assign timeout_o = 1'b0;
`endif

  assign grant_o = state_q;

endmodule

// File: tb/tb_gonso_wb_arbiter.sv
// Directed bench for gonso_wb_arbiter: reset, single transfer, round-robin, burst hold, async reset, stall.
// Built with or without GONSO_WB_ARB_TIMEOUT_EN; the stall scenario expects the matching behaviour.
`timescale 1ns/1ps
module tb_gonso_wb_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       tmo;
  int         checks = 0;
  int         failures = 0;

  gonso_wb_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
  gonso_wb_arbiter_if #(.AW(32), .DW(32)) m1_bus ();
  gonso_wb_arbiter_if #(.AW(32), .DW(32)) s_bus ();

  gonso_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int m, input logic v);
    if (m == 0) begin
      m0_bus.cyc = v;
      m0_bus.stb = v;
    end else begin
      m1_bus.cyc = v;
      m1_bus.stb = v;
    end
  endtask

  function automatic logic [1:0] oh(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int owner;
    int ack_seen;
    int tmo_seen;
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.sel = 0; m0_bus.adr = 0; m0_bus.dat_w = 0;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.sel = 0; m1_bus.adr = 0; m1_bus.dat_w = 0;
    s_bus.ack = 0; s_bus.dat_r = 0;

    // Reset values
    #12;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_bus.cyc, 1'b0);
    chk("rst_s_stb", s_bus.stb, 1'b0);
    chk("rst_s_adr", s_bus.adr, 32'h0);
    chk("rst_m0_ack", m0_bus.ack, 1'b0);
    chk("rst_m1_ack", m1_bus.ack, 1'b0);
    chk("rst_m0_dat", m0_bus.dat_r, 32'h0);
    chk("rst_tmo", tmo, 1'b0);
    mid();
    rst_n = 1'b1;
    nxt();

    // Single m0 write, slave acks two cycles after stb
    set_req(0, 1'b1);
    m0_bus.we = 1'b1; m0_bus.sel = 4'hF;
    m0_bus.adr = 32'h3000_0000; m0_bus.dat_w = 32'h1234_5678;
    mid();
    chk("t1_latency_grant", grant, 2'b00);
    chk("t1_latency_s_cyc", s_bus.cyc, 1'b0);
    nxt();
    mid();
    chk("t1_grant", grant, 2'b01);
    chk("t1_s_adr", s_bus.adr, 32'h3000_0000);
    chk("t1_s_dat", s_bus.dat_w, 32'h1234_5678);
    chk("t1_s_we", s_bus.we, 1'b1);
    chk("t1_s_sel", s_bus.sel, 4'hF);
    chk("t1_m0_ack_wait", m0_bus.ack, 1'b0);
    nxt();
    nxt();
    s_bus.ack = 1'b1; s_bus.dat_r = 32'hAAAA_5555;
    mid();
    chk("t1_m0_ack", m0_bus.ack, 1'b1);
    chk("t1_m0_dat", m0_bus.dat_r, 32'hAAAA_5555);
    chk("t1_m1_ack", m1_bus.ack, 1'b0);
    chk("t1_m1_dat", m1_bus.dat_r, 32'h0);
    nxt();
    s_bus.ack = 1'b0;
    set_req(0, 1'b0);
    mid();
    chk("t1_m0_ack_once", m0_bus.ack, 1'b0);
    chk("t1_drop_grant", grant, 2'b01);
    chk("t1_drop_s_cyc", s_bus.cyc, 1'b0);
    nxt();
    mid();
    chk("t1_release", grant, 2'b00);

    // Fresh reset, then both masters request together: strict alternation
    rst_n = 1'b0;
    mid();
    rst_n = 1'b1;
    nxt();
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    mid();
    chk("t2_latency_grant", grant, 2'b00);
    for (int r = 0; r < 10; r++) begin
      owner = r % 2;
      nxt();
      mid();
      chk($sformatf("t2_r%0d_grant", r), grant, oh(owner));
      s_bus.ack = 1'b1; s_bus.dat_r = 32'h0000_0100 + r;
      #1;
      chk($sformatf("t2_r%0d_owner_ack", r), (owner == 0) ? m0_bus.ack : m1_bus.ack, 1'b1);
      chk($sformatf("t2_r%0d_other_ack", r), (owner == 0) ? m1_bus.ack : m0_bus.ack, 1'b0);
      chk($sformatf("t2_r%0d_other_dat", r), (owner == 0) ? m1_bus.dat_r : m0_bus.dat_r, 32'h0);
      nxt();
      s_bus.ack = 1'b0;
      set_req(owner, 1'b0);
      mid();
      chk($sformatf("t2_r%0d_hold", r), grant, oh(owner));
      nxt();
      set_req(owner, 1'b1);
      mid();
      chk($sformatf("t2_r%0d_idle_grant", r), grant, 2'b00);
      chk($sformatf("t2_r%0d_idle_s_stb", r), s_bus.stb, 1'b0);
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    nxt();
    mid();
    chk("t2_quiet", grant, 2'b00);

    // m1 four-beat burst with stb gaps while m0 waits
    set_req(1, 1'b1);
    nxt();
    mid();
    chk("t3_grant", grant, 2'b10);
    set_req(0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      s_bus.ack = 1'b1; s_bus.dat_r = 32'hB000_0000 + b;
      #1;
      chk($sformatf("t3_b%0d_grant", b), grant, 2'b10);
      chk($sformatf("t3_b%0d_m1_ack", b), m1_bus.ack, 1'b1);
      chk($sformatf("t3_b%0d_m1_dat", b), m1_bus.dat_r, 32'hB000_0000 + b);
      chk($sformatf("t3_b%0d_m0_ack", b), m0_bus.ack, 1'b0);
      nxt();
      s_bus.ack = 1'b0;
      m1_bus.stb = 1'b0;
      if (b == 3) m1_bus.cyc = 1'b0;
      mid();
      chk($sformatf("t3_b%0d_gap_grant", b), grant, 2'b10);
      chk($sformatf("t3_b%0d_gap_s_stb", b), s_bus.stb, 1'b0);
      if (b < 3) begin
        chk($sformatf("t3_b%0d_gap_s_cyc", b), s_bus.cyc, 1'b1);
        nxt();
        m1_bus.stb = 1'b1;
        mid();
      end
    end
    nxt();
    mid();
    chk("t3_idle_grant", grant, 2'b00);
    chk("t3_idle_m0_ack", m0_bus.ack, 1'b0);
    nxt();
    mid();
    chk("t3_m0_grant", grant, 2'b01);
    s_bus.ack = 1'b1;
    #1;
    chk("t3_m0_ack", m0_bus.ack, 1'b1);
    nxt();
    s_bus.ack = 1'b0;
    set_req(0, 1'b0);
    nxt();
    mid();
    chk("t3_end", grant, 2'b00);

    // Asynchronous reset in the middle of an m0 transfer
    set_req(0, 1'b1);
    nxt();
    mid();
    chk("t4_grant", grant, 2'b01);
    chk("t4_s_cyc", s_bus.cyc, 1'b1);
    #1;
    s_bus.ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_s_cyc", s_bus.cyc, 1'b0);
    chk("t4_rst_s_stb", s_bus.stb, 1'b0);
    chk("t4_rst_grant", grant, 2'b00);
    chk("t4_rst_m0_ack", m0_bus.ack, 1'b0);
    mid();
    s_bus.ack = 1'b0;
    rst_n = 1'b1;
    nxt();
    mid();
    chk("t4_regrant", grant, 2'b01);
    s_bus.ack = 1'b1;
    #1;
    chk("t4_regrant_ack", m0_bus.ack, 1'b1);
    nxt();
    s_bus.ack = 1'b0;
    set_req(0, 1'b0);
    nxt();
    mid();
    chk("t4_end", grant, 2'b00);

    // m0 read to a slave that never acks
    m0_bus.we = 1'b0;
    m0_bus.adr = 32'h3000_0010;
    set_req(0, 1'b1);
    nxt();
`ifdef GONSO_WB_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      mid();
      chk($sformatf("t5_stall%0d_ack_tmo", k), {m0_bus.ack, tmo}, 2'b00);
      nxt();
    end
    mid();
    chk("t5_to_ack", m0_bus.ack, 1'b1);
    chk("t5_to_dat", m0_bus.dat_r, 32'hDEAD_BEEF);
    chk("t5_to_pulse", tmo, 1'b1);
    chk("t5_to_s_cyc", s_bus.cyc, 1'b0);
    chk("t5_to_s_stb", s_bus.stb, 1'b0);
    nxt();
    mid();
    chk("t5_after_grant", grant, 2'b00);
    chk("t5_after_tmo", tmo, 1'b0);
    chk("t5_after_ack", m0_bus.ack, 1'b0);
    nxt();
    mid();
    chk("t5_next_grant", grant, 2'b01);
    s_bus.ack = 1'b1; s_bus.dat_r = 32'h0000_0055;
    #1;
    chk("t5_next_ack", m0_bus.ack, 1'b1);
    chk("t5_next_dat", m0_bus.dat_r, 32'h0000_0055);
    chk("t5_next_tmo", tmo, 1'b0);
`else
    ack_seen = 0;
    tmo_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      mid();
      if (m0_bus.ack) ack_seen++;
      if (tmo) tmo_seen++;
      nxt();
    end
    mid();
    chk("t5_no_ack", ack_seen, 0);
    chk("t5_no_tmo", tmo_seen, 0);
    chk("t5_still_granted", grant, 2'b01);
    s_bus.ack = 1'b1; s_bus.dat_r = 32'h0000_0055;
    #1;
    chk("t5_late_ack", m0_bus.ack, 1'b1);
    chk("t5_late_dat", m0_bus.dat_r, 32'h0000_0055);
`endif
    nxt();
    s_bus.ack = 1'b0;
    set_req(0, 1'b0);
    nxt();
    mid();
    chk("t5_end", grant, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
